bilinear_csr_host: RTL and testbench

Hardware job sequencer on the initiator side of the bilinear downscaler's CSR interface. It accepts one job descriptor at a time and programs SCALE_Q, IN_W_H, OUT_W_H and CTRL, then pulses START. It polls STATUS until DONE, optionally driving the STEP/STEP_ACK handshake, then reads PERF_CYC/PERF_PIX and returns a result record. It connects directly to the downscaler top's `csr_we/csr_addr/csr_wdata/csr_rdata` ports, which use a word-indexed address and a same-cycle combinational read.

---
 rtl/bilinear_pkg.sv | 47 ++++
 rtl/bilinear_csr_host.sv | 223 ++++++++++++++++++++++
 tb/tb_bilinear_csr_host.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bilinear_pkg.sv
`default_nettype none
//==============================================================================
// Module : bilinear_pkg
// Brief  : Downscaler CSR word map, CTRL/STATUS bit indices, host FSM states.
// Rev    : 1.0
//==============================================================================
package bilinear_pkg;

  localparam logic [3:0] c_addr_ctrl     = 4'd0;
  localparam logic [3:0] c_addr_status   = 4'd1;
  localparam logic [3:0] c_addr_scale    = 4'd2;
  localparam logic [3:0] c_addr_in_wh    = 4'd3;
  localparam logic [3:0] c_addr_out_wh   = 4'd4;
  localparam logic [3:0] c_addr_perf_cyc = 4'd5;
  localparam logic [3:0] c_addr_perf_pix = 4'd6;

  localparam int unsigned c_ctrl_en        = 0;
  localparam int unsigned c_ctrl_start     = 1;
  localparam int unsigned c_ctrl_mode      = 2;
  localparam int unsigned c_ctrl_step_mode = 3;
  localparam int unsigned c_ctrl_step      = 4;

  localparam int unsigned c_stat_busy     = 0;
  localparam int unsigned c_stat_done     = 1;
  localparam int unsigned c_stat_step_ack = 3;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_WR_SCALE   = 4'd1,
    ST_WR_IN      = 4'd2,
    ST_WR_OUT     = 4'd3,
    ST_WR_EN      = 4'd4,
    ST_WR_START   = 4'd5,
    ST_SETTLE     = 4'd6,
    ST_POLL       = 4'd7,
    ST_STEP_HI    = 4'd8,
    ST_STEP_WACK  = 4'd9,
    ST_STEP_LO    = 4'd10,
    ST_STEP_WNACK = 4'd11,
    ST_RD_CYC     = 4'd12,
    ST_RD_PIX     = 4'd13,
    ST_DISABLE    = 4'd14,
    ST_RESULT     = 4'd15
  } host_state_t;

endpackage
`default_nettype wire

// File: rtl/bilinear_csr_host.sv
`default_nettype none
//==============================================================================
// Module : bilinear_csr_host
// Brief  : Job sequencer driving the bilinear downscaler CSR port: program,
//          start, poll (optional step handshake), read perf counters, report.
//          Optional wait timeout: define BILINEAR_HOST_TIMEOUT_EN.
// Rev    : 1.0
//==============================================================================
module bilinear_csr_host
  import bilinear_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 3
`ifdef BILINEAR_HOST_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 1048576
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic        job_mode,
  input  logic        job_step_mode,
  input  logic [15:0] job_in_w,
  input  logic [15:0] job_in_h,
  input  logic [15:0] job_out_w,
  input  logic [15:0] job_out_h,
  input  logic [15:0] job_inv_scale_q,
  input  logic        step_req,
  output logic        step_done,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_cycles,
  output logic [31:0] res_pixels,
  output logic        res_err,
  output logic        busy,
  output logic        csr_we,
  output logic [3:0]  csr_addr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata
);

  host_state_t r_state, w_next;

  logic        r_mode, r_step_mode, r_step_pend, r_timeout;
  logic [15:0] r_in_w, r_in_h, r_out_w, r_out_h, r_scale;
  logic [31:0] r_exp_pix, r_res_cycles, r_res_pixels;
  logic        r_res_err;
  logic [3:0]  r_settle;

  logic        w_accept, w_status_done, w_step_ack, w_wait_expired;
  logic        w_timeout_fire, w_step_done, w_we;
  logic [3:0]  w_addr;
  logic [31:0] w_wdata, w_base;

  assign w_accept      = (r_state == ST_IDLE) && job_valid;
  assign w_status_done = csr_rdata[c_stat_done] && !csr_rdata[c_stat_busy];
  assign w_step_ack    = csr_rdata[c_stat_step_ack];

`ifdef BILINEAR_HOST_TIMEOUT_EN
  logic [31:0] r_wait;

  // Restarts on every state change, so each wait state gets a fresh budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
    end else if (r_state != w_next) begin
      r_wait <= '0;
    end else if (r_wait != '1) begin
      r_wait <= r_wait + 32'd1;
    end
  end

  assign w_wait_expired = (r_wait == 32'(TIMEOUT_CYC - 1));
`else
  assign w_wait_expired = 1'b0;
`endif

  always_comb begin
    w_base                   = '0;
    w_base[c_ctrl_en]        = 1'b1;
    w_base[c_ctrl_mode]      = r_mode;
    w_base[c_ctrl_step_mode] = r_step_mode;
  end

  always_comb begin
    w_next         = r_state;
    w_we           = 1'b0;
    w_addr         = '0;
    w_wdata        = '0;
    w_step_done    = 1'b0;
    w_timeout_fire = 1'b0;
    case (r_state)
      ST_IDLE:     if (job_valid) w_next = ST_WR_SCALE;
      ST_WR_SCALE: begin
        w_we = 1'b1; w_addr = c_addr_scale; w_wdata = {16'h0, r_scale};
        w_next = ST_WR_IN;
      end
      ST_WR_IN: begin
        w_we = 1'b1; w_addr = c_addr_in_wh; w_wdata = {r_in_w, r_in_h};
        w_next = ST_WR_OUT;
      end
      ST_WR_OUT: begin
        w_we = 1'b1; w_addr = c_addr_out_wh; w_wdata = {r_out_w, r_out_h};
        w_next = ST_WR_EN;
      end
      ST_WR_EN: begin
        w_we = 1'b1; w_addr = c_addr_ctrl; w_wdata = w_base;
        w_next = ST_WR_START;
      end
      ST_WR_START: begin
        w_we = 1'b1; w_addr = c_addr_ctrl; w_wdata = w_base;
        w_wdata[c_ctrl_start] = 1'b1;
        w_next = ST_SETTLE;
      end
      ST_SETTLE:   if (r_settle == 4'd0) w_next = ST_POLL;
      ST_POLL: begin
        w_addr = c_addr_status;
        if (w_status_done) begin
          w_next = ST_RD_CYC;
        end else if (w_wait_expired) begin
          w_next = ST_RD_CYC; w_timeout_fire = 1'b1;
        end else if (r_step_mode && r_step_pend) begin
          w_next = ST_STEP_HI;
        end
      end
      ST_STEP_HI: begin
        w_we = 1'b1; w_addr = c_addr_ctrl; w_wdata = w_base;
        w_wdata[c_ctrl_step] = 1'b1;
        w_next = ST_STEP_WACK;
      end
      ST_STEP_WACK: begin
        w_addr = c_addr_status;
        if (w_step_ack) begin
          w_next = ST_STEP_LO;
        end else if (w_wait_expired) begin
          w_next = ST_RD_CYC; w_timeout_fire = 1'b1;
        end
      end
      ST_STEP_LO: begin
        w_we = 1'b1; w_addr = c_addr_ctrl; w_wdata = w_base;
        w_next = ST_STEP_WNACK;
      end
      ST_STEP_WNACK: begin
        w_addr = c_addr_status;
        if (!w_step_ack) begin
          w_next = ST_POLL; w_step_done = 1'b1;
        end else if (w_wait_expired) begin
          w_next = ST_RD_CYC; w_timeout_fire = 1'b1;
        end
      end
      ST_RD_CYC:  begin w_addr = c_addr_perf_cyc; w_next = ST_RD_PIX; end
      ST_RD_PIX:  begin w_addr = c_addr_perf_pix; w_next = ST_DISABLE; end
      ST_DISABLE: begin w_we = 1'b1; w_addr = c_addr_ctrl; w_next = ST_RESULT; end
      ST_RESULT:  if (res_ready) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_mode       <= 1'b0;
      r_step_mode  <= 1'b0;
      r_in_w       <= '0;
      r_in_h       <= '0;
      r_out_w      <= '0;
      r_out_h      <= '0;
      r_scale      <= '0;
      r_exp_pix    <= '0;
      r_settle     <= '0;
      r_step_pend  <= 1'b0;
      r_timeout    <= 1'b0;
      r_res_cycles <= '0;
      r_res_pixels <= '0;
      r_res_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mode      <= job_mode;
        r_step_mode <= job_step_mode;
        r_in_w      <= job_in_w;
        r_in_h      <= job_in_h;
        r_out_w     <= job_out_w;
        r_out_h     <= job_out_h;
        r_scale     <= job_inv_scale_q;
        r_exp_pix   <= 32'(job_out_w) * 32'(job_out_h);
        r_timeout   <= 1'b0;
      end else if (w_timeout_fire) begin
        r_timeout <= 1'b1;
      end
      if (r_state == ST_WR_START) begin
        r_settle <= 4'(SETTLE_CYC - 1);
      end else if (r_state == ST_SETTLE && r_settle != 4'd0) begin
        r_settle <= r_settle - 4'd1;
      end
      // A request landing while one is already pending is simply absorbed.
      if (r_state == ST_IDLE || w_next == ST_IDLE || w_step_done) begin
        r_step_pend <= 1'b0;
      end else if (step_req) begin
        r_step_pend <= 1'b1;
      end
      if (r_state == ST_RD_CYC) r_res_cycles <= csr_rdata;
      if (r_state == ST_RD_PIX) begin
        r_res_pixels <= csr_rdata;
        r_res_err    <= (csr_rdata != r_exp_pix) || r_timeout;
      end
    end
  end

  assign job_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign res_valid  = (r_state == ST_RESULT);
  assign res_cycles = r_res_cycles;
  assign res_pixels = r_res_pixels;
  assign res_err    = r_res_err;
  assign step_done  = w_step_done;
  assign csr_we     = w_we;
  assign csr_addr   = w_addr;
  assign csr_wdata  = w_wdata;

endmodule
`default_nettype wire

// File: tb/tb_bilinear_csr_host.sv
`default_nettype none
//==============================================================================
// Module : tb_bilinear_csr_host
// Brief  : Scoreboard bench with a behavioural downscaler CSR stub.
// Rev    : 1.0
//==============================================================================
module tb_bilinear_csr_host;

  localparam int SETTLE = 3;
  localparam int TMO    = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_valid = 1'b0, job_mode = 1'b0, job_step_mode = 1'b0;
  logic [15:0] job_in_w = '0, job_in_h = '0, job_out_w = '0, job_out_h = '0;
  logic [15:0] job_inv_scale_q = '0;
  logic        step_req = 1'b0, res_ready = 1'b0;
  logic        job_ready, step_done, res_valid, res_err, busy, csr_we;
  logic [31:0] res_cycles, res_pixels, csr_wdata, csr_rdata;
  logic [3:0]  csr_addr;

  always #5 clk = ~clk;

  bilinear_csr_host #(
    .SETTLE_CYC(SETTLE)
`ifdef BILINEAR_HOST_TIMEOUT_EN
    , .TIMEOUT_CYC(TMO)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_mode(job_mode), .job_step_mode(job_step_mode),
    .job_in_w(job_in_w), .job_in_h(job_in_h),
    .job_out_w(job_out_w), .job_out_h(job_out_h),
    .job_inv_scale_q(job_inv_scale_q),
    .step_req(step_req), .step_done(step_done),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_cycles(res_cycles), .res_pixels(res_pixels), .res_err(res_err),
    .busy(busy),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata)
  );

  // Downscaler stub: START runs for stub_run cycles, STEP level echoed 4 cycles later.
  logic [31:0] stub_run = 32'd100, stub_cyc = '0, stub_pix = '0, s_runcnt = '0;
  logic        s_busy = 1'b0, s_done = 1'b0, s_ack = 1'b0, s_tgt = 1'b0;
  int          s_ackcnt = 0;

  always @(posedge clk) begin
    if (csr_we && csr_addr == 4'd0 && csr_wdata[1]) begin
      s_busy <= 1'b1; s_done <= 1'b0; s_runcnt <= stub_run;
    end else if (s_busy) begin
      if (s_runcnt <= 32'd1) begin s_busy <= 1'b0; s_done <= 1'b1; end
      else s_runcnt <= s_runcnt - 32'd1;
    end
    if (csr_we && csr_addr == 4'd0) begin
      s_tgt <= csr_wdata[4]; s_ackcnt <= 4;
    end else if (s_ackcnt != 0) begin
      s_ackcnt <= s_ackcnt - 1;
      if (s_ackcnt == 1) s_ack <= s_tgt;
    end
  end

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      4'd1:    csr_rdata = {28'h0, s_ack, 1'b0, s_done, s_busy};
      4'd5:    csr_rdata = stub_cyc;
      4'd6:    csr_rdata = stub_pix;
      default: csr_rdata = 32'h0;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [3:0] a; logic [31:0] d; int t; } wr_t;
  typedef struct { logic [31:0] c; logic [31:0] p; logic e; int steps; } res_t;
  wr_t  exp_wr[$];
  res_t exp_res[$];
  wr_t  mw;
  res_t mr;

  int checks = 0, errors = 0;
  int poll_exp = -1, done_cyc = -1, rd5_cyc = -1, tmo_exp = -1, step_seen = 0;
  logic prev_rv = 1'b0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endfunction

  function automatic void push_wr(input logic [3:0] a, input logic [31:0] d, input int t);
    wr_t w;
    w.a = a; w.d = d; w.t = t;
    exp_wr.push_back(w);
  endfunction

  // Monitor: pops expectations whenever the DUT writes CSRs or hands over a result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (csr_we) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_csr_write", {csr_addr, csr_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          mw = exp_wr.pop_front();
          chk("wr_addr", csr_addr, mw.a);
          chk("wr_data", csr_wdata, mw.d);
          if (mw.t >= 0) chk("wr_cycle", cyc, mw.t);
        end
      end else begin
        checks++;
        if (csr_wdata != 32'h0 || !(csr_addr inside {4'd0, 4'd1, 4'd5, 4'd6})) begin
          errors++;
          $display("FAIL idle_bus: got addr %0d data 0x%0h required data 0 and a read address", csr_addr, csr_wdata);
        end
        if (csr_addr == 4'd1) begin
          if (poll_exp >= 0) begin chk("first_status_cycle", cyc, poll_exp); poll_exp = -1; end
          if (csr_rdata[1] && !csr_rdata[0] && done_cyc < 0) done_cyc = cyc;
        end
        if (csr_addr == 4'd5) begin
          rd5_cyc = cyc;
          if (done_cyc >= 0) chk("rd_cyc_after_done", cyc, done_cyc + 1);
          if (tmo_exp >= 0) begin chk("timeout_rd_cyc", cyc, tmo_exp); tmo_exp = -1; end
        end
      end
      if (step_done) step_seen++;
      if (res_valid && !prev_rv) chk("res_valid_latency", cyc, rd5_cyc + 3);
      if (res_valid && res_ready) begin
        if (exp_res.size() == 0) begin
          chk("unexpected_result", res_cycles, ~res_cycles);
        end else begin
          mr = exp_res.pop_front();
          chk("res_cycles", res_cycles, mr.c);
          chk("res_pixels", res_pixels, mr.p);
          chk("res_err", res_err, mr.e);
          chk("step_done_count", step_seen, mr.steps);
        end
        done_cyc = -1; rd5_cyc = -1; step_seen = 0;
      end
    end
    prev_rv = res_valid;
  end

  task automatic run_job(input bit dir, input bit mode, input bit smode, input int nsteps,
                         input int run, input bit bad, input int bp, input bit rst_mid,
                         input bit tmo);
    logic [15:0] iw, ih, ow, oh, sc;
    logic [31:0] b, prod, hc, hp;
    logic        he;
    res_t        r;
    int          acc, g;
    if (dir) begin
      iw = 16'd64; ih = 16'd64; ow = 16'd32; oh = 16'd32; sc = 16'h0200;
    end else begin
      iw = 16'($urandom_range(16, 2048)); ih = 16'($urandom_range(16, 2048));
      ow = 16'($urandom_range(1, int'(iw))); oh = 16'($urandom_range(1, int'(ih)));
      sc = 16'($urandom);
    end
    prod     = 32'(int'(ow) * int'(oh));
    stub_run = tmo ? 32'h7fff_ffff : 32'(run);
    stub_cyc = dir ? 32'd100 : $urandom;
    stub_pix = bad ? prod + 32'd7 : prod;

    @(posedge clk); #1;
    chk("job_ready_idle", job_ready, 1);
    job_valid = 1'b1; job_mode = mode; job_step_mode = smode;
    job_in_w = iw; job_in_h = ih; job_out_w = ow; job_out_h = oh; job_inv_scale_q = sc;
    @(posedge clk); #1;
    acc = cyc;
    job_valid = 1'b0;
    job_in_w = 16'($urandom); job_in_h = 16'($urandom); job_out_w = 16'($urandom);
    job_out_h = 16'($urandom); job_inv_scale_q = 16'($urandom);
    job_mode = 1'($urandom); job_step_mode = 1'($urandom);

    b = 32'h1 | {28'h0, smode, mode, 2'b00};
    push_wr(4'd2, {16'h0, sc}, acc);
    push_wr(4'd3, {iw, ih}, acc + 1);
    push_wr(4'd4, {ow, oh}, acc + 2);
    push_wr(4'd0, b, acc + 3);
    push_wr(4'd0, b | 32'h2, acc + 4);
    for (int i = 0; i < nsteps; i++) begin
      push_wr(4'd0, b | 32'h10, -1);
      push_wr(4'd0, b, -1);
    end
    push_wr(4'd0, 32'h0, -1);
    r.c = stub_cyc; r.p = stub_pix; r.e = bad || tmo; r.steps = nsteps;
    exp_res.push_back(r);
    poll_exp = acc + 5 + SETTLE;
    if (tmo) tmo_exp = acc + 5 + SETTLE + TMO;

    if (rst_mid) begin
      g = 0;
      do begin @(negedge clk); g++; end while (!(csr_addr == 4'd1 && !csr_we) && g < 100);
      chk("reached_poll", csr_addr, 1);
      repeat (5) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_ctl", {job_ready, step_done, res_valid, res_err, busy, csr_we, csr_addr}, 10'b10_0000_0000);
      chk("rst_mid_res", {res_cycles, res_pixels}, 64'h0);
      chk("rst_mid_wdata", csr_wdata, 32'h0);
      exp_wr.delete(); exp_res.delete();
      poll_exp = -1; done_cyc = -1; rd5_cyc = -1; tmo_exp = -1; step_seen = 0;
      repeat (3) begin @(negedge clk); chk("no_csr_in_reset", {csr_we, csr_addr}, 5'h0); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      return;
    end

    for (int i = 0; i < nsteps; i++) begin
      step_req = 1'b1;
      @(posedge clk); #1;
      step_req = 1'b0;
      g = 0;
      do begin @(negedge clk); g++; end while (!step_done && g < 300);
      chk("step_done_seen", step_done, 1);
      @(posedge clk); #1;
    end

    g = 0;
    while (!res_valid && g < 4000) begin @(negedge clk); g++; end
    chk("res_valid_seen", res_valid, 1);
    if (!res_valid) begin
      exp_wr.delete(); exp_res.delete();
      return;
    end
    hc = res_cycles; hp = res_pixels; he = res_err;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_hold_cycles", res_cycles, hc);
      chk("bp_hold_pixels", res_pixels, hp);
      chk("bp_flags", {res_valid, res_err, job_ready}, {1'b1, he, 1'b0});
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("job_ready_after_result", {job_ready, busy}, 2'b10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit sm;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", {job_ready, step_done, res_valid, res_err, busy, csr_we, csr_addr}, 10'b10_0000_0000);
    chk("reset_res", {res_cycles, res_pixels}, 64'h0);
    chk("reset_wdata", csr_wdata, 32'h0);
    rst_n = 1'b1;

    run_job(1, 0, 0, 0, 100, 0, 0, 0, 0);
    run_job(0, 1, 0, 0, int'($urandom_range(30, 80)), 1, 0, 0, 0);
    run_job(0, 0, 1, 3, 400, 0, 0, 0, 0);
    run_job(0, 1'($urandom), 0, 0, 50, 0, 20, 0, 0);
    run_job(0, 0, 0, 0, 3000, 0, 0, 1, 0);
    run_job(0, 1, 0, 0, 60, 0, 0, 0, 0);
    for (int j = 0; j < 6; j++) begin
      sm = 1'($urandom);
      run_job(0, 1'($urandom), sm, sm ? int'($urandom_range(0, 2)) : 0,
              sm ? int'($urandom_range(300, 400)) : int'($urandom_range(10, 120)),
              1'($urandom), int'($urandom_range(0, 3)), 0, 0);
    end
`ifdef BILINEAR_HOST_TIMEOUT_EN
    run_job(0, 0, 0, 0, 0, 0, 0, 0, 1);
`endif
    repeat (3) @(negedge clk);
    chk("queues_empty", 64'(exp_wr.size() + exp_res.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
